gxgy_win_gen: RTL

GXGY_WIN_GEN -- requirements
Module: gxgy_win_gen

---
 rtl/prei_pkg.sv | 16 +
 rtl/gxgy_line_buf.sv | 31 +++
 rtl/gxgy_win_gen.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/prei_pkg.sv
// Shared definitions for the gradient window generator.
//   gxgy_state_t : frame sequencer states (IDLE / PRIME / RUN)
//   PIX_W        : width of one luma sample
//   WROW_W       : width of one 3-pixel window row (3 x PIX_W)
package prei_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } gxgy_state_t;

  localparam int PIX_W  = 8;
  localparam int WROW_W = 3 * PIX_W;

endpackage

// File: rtl/gxgy_line_buf.sv
// One line of pixel storage.
//   clk   : clock
//   we    : write enable; wdata is written to addr on the rising edge
//   addr  : shared read/write address
//   wdata : byte to store
//   rdata : byte currently stored at addr (combinational read, so the old
//           value is visible in the same cycle it is being overwritten)
module gxgy_line_buf
  import prei_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/gxgy_win_gen.sv
// 3x3 sliding window generator for a raster luma stream.
//   clk, rstn   : clock, asynchronous active-low reset
//   sof         : start of frame, qualified by pix_valid; marks pixel (0,0)
//   pix_valid   : pix_data valid this cycle
//   pix_data    : 8-bit luma sample
//   gxgyrun     : x1/x2/x3 hold a complete window this cycle
//   x1, x2, x3  : window rows for lines r-2, r-1, r; [7:0] = column c,
//                 [15:8] = column c-1, [23:16] = column c-2
//   frame_done  : one-cycle pulse after the last pixel of a frame
//   busy        : a frame is in progress (PRIME or RUN)
module gxgy_win_gen
  import prei_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              sof,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  output logic              gxgyrun,
  output logic [WROW_W-1:0] x1,
  output logic [WROW_W-1:0] x2,
  output logic [WROW_W-1:0] x3,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  gxgy_state_t       state_reg, state_next;
  logic [CW-1:0]     col_reg, col_next;
  logic [RW-1:0]     row_reg, row_next;
  logic              run_reg, run_next;
  logic              done_reg, done_next;
  logic [WROW_W-1:0] top_reg, mid_reg, bot_reg;

  logic              accept;
  logic              last_col;
  logic [CW-1:0]     pc;
  logic [RW-1:0]     pr;
  logic [PIX_W-1:0]  lb_wdata [2];
  logic [PIX_W-1:0]  lb_rdata [2];

  // A sof pixel is taken in any state and is always pixel (0,0), so the
  // effective position of the current pixel overrides the counters.
  assign accept   = pix_valid & (sof | (state_reg != ST_IDLE));
  assign pc       = sof ? '0 : col_reg;
  assign pr       = sof ? '0 : row_reg;
  assign last_col = (pc == LAST_COL);

  // Buffer 0 holds line r-1, buffer 1 holds line r-2. Writing the old
  // line r-1 byte into buffer 1 at the same address ages the column by
  // one line in a single step.
  assign lb_wdata[0] = pix_data;
  assign lb_wdata[1] = lb_rdata[0];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lb
      gxgy_line_buf #(
        .DEPTH (IMG_W),
        .AW    (CW)
      ) u_lb (
        .clk   (clk),
        .we    (accept),
        .addr  (pc),
        .wdata (lb_wdata[gi]),
        .rdata (lb_rdata[gi])
      );
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    done_next  = 1'b0;
    run_next   = 1'b0;
    if (accept) begin
      // Windows are only complete once two full lines and two columns of
      // the current line have been seen; this also hides stale buffer data
      // and shift-register columns left over from the previous line.
      run_next = (pr >= RW'(2)) && (pc >= CW'(2));
      if (last_col) begin
        col_next = '0;
        row_next = pr + 1'b1;
      end else begin
        col_next = pc + 1'b1;
        row_next = pr;
      end
      if (sof) begin
        state_next = ST_PRIME;
      end else begin
        case (state_reg)
          ST_PRIME: begin
            if ((pr == RW'(1)) && last_col) begin
              state_next = ST_RUN;
            end
          end
          ST_RUN: begin
            if ((pr == LAST_ROW) && last_col) begin
              state_next = ST_IDLE;
              col_next   = '0;
              row_next   = '0;
              done_next  = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      run_reg   <= 1'b0;
      done_reg  <= 1'b0;
      top_reg   <= '0;
      mid_reg   <= '0;
      bot_reg   <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      run_reg   <= run_next;
      done_reg  <= done_next;
      if (accept) begin
        top_reg <= {top_reg[WROW_W-PIX_W-1:0], lb_rdata[1]};
        mid_reg <= {mid_reg[WROW_W-PIX_W-1:0], lb_rdata[0]};
        bot_reg <= {bot_reg[WROW_W-PIX_W-1:0], pix_data};
      end
    end
  end

  assign gxgyrun    = run_reg;
  assign x1         = top_reg;
  assign x2         = mid_reg;
  assign x3         = bot_reg;
  assign frame_done = done_reg;
  assign busy       = (state_reg != ST_IDLE);

endmodule
